complex_mac_pipe: RTL and testbench



---
 rtl/complex_mac_pipe_pkg.sv | 18 +
 rtl/complex_mac_pipe_if.sv | 25 ++
 rtl/complex_mac_pipe_round_sat.sv | 34 +++
 rtl/complex_mac_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_complex_mac_pipe.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/complex_mac_pipe_pkg.sv
// Shared opcode encoding and default Q-format widths for the complex MAC pipeline.
package complex_mac_pipe_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 15;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_CMAC      = 3'b001,
        OP_CMAC_INIT = 3'b010,
        OP_CONJMUL   = 3'b011,
        OP_MUL       = 3'b100,
        OP_MULADD    = 3'b101,
        OP_MULSUB    = 3'b110,
        OP_MAX       = 3'b111
    } opcode_e;

endpackage

// File: rtl/complex_mac_pipe_if.sv
// Operand/result stream bundle for complex_mac_pipe: valid/ready on both sides.
interface complex_mac_pipe_if #(
    parameter int DATA_WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              opcode;
    logic [2*DATA_WIDTH-1:0] din_a;
    logic [2*DATA_WIDTH-1:0] din_b;
    logic [2*DATA_WIDTH-1:0] din_c;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*DATA_WIDTH-1:0] dout;
    logic                    sat;

    modport master (
        output in_valid, opcode, din_a, din_b, din_c, out_ready,
        input  in_ready, out_valid, dout, sat
    );

    modport slave (
        input  in_valid, opcode, din_a, din_b, din_c, out_ready,
        output in_ready, out_valid, dout, sat
    );
endinterface

// File: rtl/complex_mac_pipe_round_sat.sv
// Combinational round-half-up and saturate of one wide signed component down to DATA_WIDTH.
module cplx_round_sat #(
    parameter int IN_WIDTH   = 40,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15
) (
    input  logic signed [IN_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0]      dout_o,
    output logic                       clamp_o
);
    // One extra bit so the rounding bias can never wrap the input.
    localparam int RW = IN_WIDTH + 1;
    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (DATA_WIDTH - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MINV = -(RW'(1) <<< (DATA_WIDTH - 1));

    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] shifted;

    assign biased  = RW'(din_i) + HALF;
    assign shifted = biased >>> FRAC_BITS;

    always_comb begin
        dout_o  = shifted[DATA_WIDTH-1:0];
        clamp_o = 1'b0;
        if (shifted > MAXV) begin
            dout_o  = MAXV[DATA_WIDTH-1:0];
            clamp_o = 1'b1;
        end else if (shifted < MINV) begin
            dout_o  = MINV[DATA_WIDTH-1:0];
            clamp_o = 1'b1;
        end
    end
endmodule

// File: rtl/complex_mac_pipe.sv
// Four-stage complex multiply / multiply-add / CMAC unit with a whole-pipe stall on out_ready.
module complex_mac_pipe
    import complex_mac_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + 8
) (
    input  logic              clk,
    input  logic              rst,
    complex_mac_pipe_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2*DW;
    localparam int SW = 2*DW + 2;
    localparam int AW = ACC_WIDTH;

    logic          adv;
    logic          out_valid_q, sat_q, sat_d;
    logic [PW-1:0] dout_q, dout_d;

    assign adv           = ~(out_valid_q & ~bus.out_ready);
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.sat       = sat_q;

    // S1: operand capture
    logic          v1_q;
    opcode_e       op1_q;
    logic [PW-1:0] a1_q, b1_q, c1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            op1_q <= OP_NOP;
            a1_q  <= '0;
            b1_q  <= '0;
            c1_q  <= '0;
        end else if (adv) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                op1_q <= opcode_e'(bus.opcode);
                a1_q  <= bus.din_a;
                b1_q  <= bus.din_b;
                c1_q  <= bus.din_c;
            end
        end
    end

    // S2: four full-precision products, kept here so they land in DSP slices
    logic signed [PW-1:0] ar1, ai1, br1, bi1;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic                 v2_q;
    opcode_e              op2_q;
    logic [PW-1:0]        a2_q, b2_q, c2_q;

    assign ar1 = PW'($signed(a1_q[PW-1:DW]));
    assign ai1 = PW'($signed(a1_q[DW-1:0]));
    assign br1 = PW'($signed(b1_q[PW-1:DW]));
    assign bi1 = PW'($signed(b1_q[DW-1:0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            op2_q  <= OP_NOP;
            a2_q   <= '0;
            b2_q   <= '0;
            c2_q   <= '0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else if (adv) begin
            v2_q <= v1_q;
            if (v1_q) begin
                op2_q  <= op1_q;
                a2_q   <= a1_q;
                b2_q   <= b1_q;
                c2_q   <= c1_q;
                p_rr_q <= ar1 * br1;
                p_ii_q <= ai1 * bi1;
                p_ri_q <= ar1 * bi1;
                p_ir_q <= ai1 * br1;
            end
        end
    end

    // S3: combine; index 0 is I, index 1 is Q
    logic signed [SW-1:0] rr, ii, ri, ir, cr, ci;
    logic signed [AW-1:0] pa_r, pa_i;
    logic signed [DW-1:0] ar2, ai2, br2, bi2;
    logic signed [AW-1:0] acc_q [2];
    logic signed [AW-1:0] acc_d [2];
    logic signed [AW-1:0] res_d [2];
    logic signed [AW-1:0] r3_q  [2];
    logic                 v3_q;
    opcode_e              op3_q;

    assign rr   = SW'(p_rr_q);
    assign ii   = SW'(p_ii_q);
    assign ri   = SW'(p_ri_q);
    assign ir   = SW'(p_ir_q);
    assign cr   = SW'($signed(c2_q[PW-1:DW])) <<< FRAC_BITS;
    assign ci   = SW'($signed(c2_q[DW-1:0])) <<< FRAC_BITS;
    assign pa_r = AW'(p_rr_q) - AW'(p_ii_q);
    assign pa_i = AW'(p_ri_q) + AW'(p_ir_q);
    assign ar2  = $signed(a2_q[PW-1:DW]);
    assign ai2  = $signed(a2_q[DW-1:0]);
    assign br2  = $signed(b2_q[PW-1:DW]);
    assign bi2  = $signed(b2_q[DW-1:0]);

    always_comb begin
        res_d[0] = '0;
        res_d[1] = '0;
        acc_d[0] = acc_q[0];
        acc_d[1] = acc_q[1];
        case (op2_q)
            OP_MUL: begin
                res_d[0] = AW'(rr - ii);
                res_d[1] = AW'(ri + ir);
            end
            OP_MULADD: begin
                res_d[0] = AW'(rr - ii + cr);
                res_d[1] = AW'(ri + ir + ci);
            end
            OP_MULSUB: begin
                res_d[0] = AW'(rr - ii - cr);
                res_d[1] = AW'(ri + ir - ci);
            end
            OP_CONJMUL: begin
                res_d[0] = AW'(rr + ii);
                res_d[1] = AW'(ir - ri);
            end
            OP_MAX: begin
                res_d[0] = AW'((ar2 > br2) ? ar2 : br2);
                res_d[1] = AW'((ai2 > bi2) ? ai2 : bi2);
            end
            OP_CMAC_INIT: begin
                acc_d[0] = pa_r;
                acc_d[1] = pa_i;
                res_d[0] = pa_r;
                res_d[1] = pa_i;
            end
            OP_CMAC: begin
                acc_d[0] = acc_q[0] + pa_r;
                acc_d[1] = acc_q[1] + pa_i;
                res_d[0] = acc_q[0] + pa_r;
                res_d[1] = acc_q[1] + pa_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q     <= 1'b0;
            op3_q    <= OP_NOP;
            r3_q[0]  <= '0;
            r3_q[1]  <= '0;
            acc_q[0] <= '0;
            acc_q[1] <= '0;
        end else if (adv) begin
            v3_q <= v2_q;
            if (v2_q) begin
                op3_q    <= op2_q;
                r3_q[0]  <= res_d[0];
                r3_q[1]  <= res_d[1];
                acc_q[0] <= acc_d[0];
                acc_q[1] <= acc_d[1];
            end
        end
    end

    // S4: round/saturate each component, then output register
    logic [DW-1:0] rs_val   [2];
    logic          rs_clamp [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_round_sat
            cplx_round_sat #(
                .IN_WIDTH  (AW),
                .DATA_WIDTH(DW),
                .FRAC_BITS (FRAC_BITS)
            ) u_round_sat (
                .din_i  (r3_q[gi]),
                .dout_o (rs_val[gi]),
                .clamp_o(rs_clamp[gi])
            );
        end
    endgenerate

    always_comb begin
        dout_d = {rs_val[0], rs_val[1]};
        sat_d  = rs_clamp[0] | rs_clamp[1];
        if (op3_q == OP_MAX) begin
            dout_d = {r3_q[0][DW-1:0], r3_q[1][DW-1:0]};
            sat_d  = 1'b0;
        end else if (op3_q == OP_NOP) begin
            dout_d = '0;
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v3_q;
            if (v3_q) begin
                dout_q <= dout_d;
                sat_q  <= sat_d;
            end
        end
    end
endmodule

// File: tb/tb_complex_mac_pipe.sv
// Scoreboard bench for complex_mac_pipe: directed Q15 cases, stall, random traffic and mid-stream reset.
module tb_complex_mac_pipe;
    import complex_mac_pipe_pkg::*;

    localparam int DW   = 16;
    localparam int FRAC = 15;
    localparam int AW   = 2*DW + 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    complex_mac_pipe_if #(.DATA_WIDTH(DW)) bus ();

    complex_mac_pipe #(
        .DATA_WIDTH(DW),
        .FRAC_BITS (FRAC),
        .ACC_WIDTH (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] dout;
        logic        sat;
        bit          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        expq[$];
    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          cyc     = 0;
    longint      m_acc_i = 0;
    longint      m_acc_q = 0;
    bit          rand_on = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_dout;
    logic        prev_sat;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint wrap_acc(input longint x);
        longint y;
        y = x <<< (64 - AW);
        return y >>> (64 - AW);
    endfunction

    function automatic void rsat(input longint x, output logic [15:0] v, output logic cl);
        longint r;
        r = (x + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        cl = 1'b1;
        if (r > 32767)       v = 16'h7FFF;
        else if (r < -32768) v = 16'h8000;
        else begin
            v  = r[15:0];
            cl = 1'b0;
        end
    endfunction

    // Reference: plain integer arithmetic on Q15 values, acc kept as a wrapping 40-bit integer.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, b, c,
                                      output logic [31:0] d, output logic s);
        longint ar, ai, br, bi, cre, cim, pr, pi, xi, xq, mi, mq;
        logic [15:0] vi, vq;
        logic ci_, cq_;
        bit scale;
        ar = sx(a[31:16]); ai = sx(a[15:0]);
        br = sx(b[31:16]); bi = sx(b[15:0]);
        cre = sx(c[31:16]) * 32768; cim = sx(c[15:0]) * 32768;
        pr = ar*br - ai*bi;
        pi = ar*bi + ai*br;
        xi = 0; xq = 0; scale = 1; d = '0; s = 1'b0;
        case (op)
            OP_MUL:       begin xi = pr;        xq = pi;        end
            OP_MULADD:    begin xi = pr + cre;  xq = pi + cim;  end
            OP_MULSUB:    begin xi = pr - cre;  xq = pi - cim;  end
            OP_CONJMUL:   begin xi = ar*br + ai*bi; xq = ai*br - ar*bi; end
            OP_CMAC_INIT: begin
                m_acc_i = wrap_acc(pr); m_acc_q = wrap_acc(pi);
                xi = m_acc_i; xq = m_acc_q;
            end
            OP_CMAC: begin
                m_acc_i = wrap_acc(m_acc_i + pr); m_acc_q = wrap_acc(m_acc_q + pi);
                xi = m_acc_i; xq = m_acc_q;
            end
            OP_MAX: begin
                mi = (ar > br) ? ar : br;
                mq = (ai > bi) ? ai : bi;
                d = {mi[15:0], mq[15:0]};
                scale = 0;
            end
            default: scale = 0;
        endcase
        if (scale) begin
            rsat(xi, vi, ci_);
            rsat(xq, vq, cq_);
            d = {vi, vq};
            s = ci_ | cq_;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, b, c,
                        input bit use_exp = 0, input logic [31:0] ed = '0,
                        input logic es = 1'b0, input bit lat = 0);
        exp_t e;
        logic [31:0] md;
        logic ms;
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.din_a    = a;
        bus.din_b    = b;
        bus.din_c    = c;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ref_model(op, a, b, c, md, ms);
                e.dout    = use_exp ? ed : md;
                e.sat     = use_exp ? es : ms;
                e.lat     = lat;
                e.acc_cyc = cyc;
                expq.push_back(e);
                done = 1;
                $display("issue op=%03b a=%08h b=%08h c=%08h exp=%08h sat=%0b", op, a, b, c, e.dout, e.sat);
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && expq.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_pending", 32'(expq.size()), 32'd0);
    endtask

    // Monitor: pops on every transfer, and checks hold/in_ready while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (prev_stall) begin
                    check("stall_hold_dout", bus.dout, prev_dout);
                    check("stall_hold_sat", 32'(bus.sat), 32'(prev_sat));
                end
                if (!bus.out_ready) begin
                    check("in_ready_on_stall", 32'(bus.in_ready), 32'd0);
                    prev_stall = 1;
                    prev_dout  = bus.dout;
                    prev_sat   = bus.sat;
                end else begin
                    prev_stall = 0;
                    if (expq.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_output: got 0x%08h, required no output", bus.dout);
                    end else begin
                        e = expq.pop_front();
                        $display("result dout=%08h sat=%0b exp=%08h/%0b", bus.dout, bus.sat, e.dout, e.sat);
                        check("result_dout", bus.dout, e.dout);
                        check("result_sat", 32'(bus.sat), 32'(e.sat));
                        if (e.lat) check("latency", 32'(cyc - e.acc_cyc), 32'd4);
                    end
                end
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.opcode    = 3'b000;
        bus.din_a     = '0;
        bus.din_b     = '0;
        bus.din_c     = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_dout", bus.dout, 32'd0);
        check("reset_sat", 32'(bus.sat), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        send(OP_MUL, 32'h4000_0000, 32'h4000_4000, 32'h0, 1, 32'h2000_2000, 1'b0, 1);
        drain();

        send(OP_MUL,       32'h8000_0000, 32'h8000_0000, 32'h0,         1, 32'h7FFF_0000, 1'b1);
        send(OP_MULSUB,    32'h4000_0000, 32'h4000_0000, 32'h1000_0000, 1, 32'h1000_0000, 1'b0);
        send(OP_MAX,       32'h1234_8000, 32'h0FFF_7FFF, 32'h0,         1, 32'h1234_7FFF, 1'b0);
        send(OP_CONJMUL,   32'h0000_4000, 32'h0000_4000, 32'h0,         1, 32'h2000_0000, 1'b0);
        send(OP_CMAC_INIT, 32'h4000_0000, 32'h4000_0000, 32'h0,         1, 32'h2000_0000, 1'b0);
        send(OP_CMAC,      32'h4000_0000, 32'h4000_0000, 32'h0,         1, 32'h4000_0000, 1'b0);
        send(OP_CMAC,      32'h4000_0000, 32'h4000_0000, 32'h0,         1, 32'h6000_0000, 1'b0);
        send(OP_CMAC,      32'h4000_0000, 32'h4000_0000, 32'h0,         1, 32'h7FFF_0000, 1'b1);
        send(OP_NOP,       32'h1234_5678, 32'h7FFF_7FFF, 32'h0,         1, 32'h0000_0000, 1'b0);
        send(OP_MULADD,    32'h4000_0000, 32'h4000_0000, 32'h1000_1000, 1, 32'h3000_1000, 1'b0);
        drain();

        fork
            begin
                for (int k = 0; k < 8; k++) send(OP_MUL, $urandom, $urandom, $urandom);
            end
            begin
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        rand_on = 1;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
                end
                rand_on = 0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        for (int k = 0; k < 4; k++) send(OP_MUL, 32'h4000_0000, 32'h4000_0000, 32'h0);
        check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_reset_dout", bus.dout, 32'd0);
        check("mid_reset_sat", 32'(bus.sat), 32'd0);
        expq.delete();
        m_acc_i = 0;
        m_acc_q = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(OP_CMAC, 32'h4000_0000, 32'h4000_0000, 32'h0, 1, 32'h2000_0000, 1'b0);
        drain();
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
